adder_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit: the generalised successor of the team's fixed-width ripple adder. It splits a WIDTH-bit ripple-carry chain into CHUNK-bit stages separated by registers, so the datapath width no longer bounds the clock period. It adds a subtract mode, a carry/borrow input, signed-overflow and zero flags, and valid/ready flow control. It sits between operand-issue logic and any consumer that can accept multi-cycle arithmetic results, such as address generation or a multi-cycle execute path.

---
 rtl/adder_pipe.sv | 114 +++++++++++
 tb/tb_adder_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: a WIDTH-bit ripple chain split into CHUNK-bit registered stages,
// with carry/borrow in, carry/overflow/zero flags and a global-stall valid/ready handshake.
module adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  if (CHUNK == 0 || STAGES < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage k registers hold the full-width operands and partial sum: bits below the processed
  // boundary of s_q are final, bits above it in a_q/b_q are still to be added.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              cmsb_q;

  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              cmsb_d;
  logic              adv;

  assign valid_o    = v_q[LAST];
  assign sum_o      = s_q[LAST];
  assign carry_o    = c_q[LAST];
  assign overflow_o = cmsb_q ^ c_q[LAST];
  assign zero_o     = (s_q[LAST] == '0);

  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;

  // Subtraction is A + ~B + ~borrow, so carry_o reads as "no borrow".
  always_comb begin
    a_in = '{default: '0};
    b_in = '{default: '0};
    s_in = '{default: '0};
    c_in = '0;
    v_in = '0;
    a_in[0] = data0_i;
    b_in[0] = sub_i ? ~data1_i : data1_i;
    c_in[0] = carry_i ^ sub_i;
    v_in[0] = valid_i;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic [CHUNK:0] part;
    part = '0;
    s_d  = '{default: '0};
    c_d  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      part = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_in[k]};
      s_d[k] = s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k] = part[CHUNK];
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign cmsb_d = s_d[LAST][WIDTH-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
      s_q    <= '{default: '0};
      c_q    <= '0;
      v_q    <= '0;
      cmsb_q <= 1'b0;
    end else if (adv) begin
      a_q    <= a_in;
      b_q    <= b_in;
      s_q    <= s_d;
      c_q    <= c_d;
      v_q    <= v_in;
      cmsb_q <= cmsb_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed corner cases, randomized streams with backpressure against an
// arithmetic reference model, mid-stream reset, and degenerate parameterisations.
module tb_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, op_carry, op_sub;
  logic [31:0] op_a, op_b;
  logic        res_valid, res_ready, res_carry, res_ovf, res_zero;
  logic [31:0] res_sum;

  logic       s1_valid, s1_ready, s1_carry, s1_sub, s1_rvalid, s1_rready, s1_co, s1_ovf, s1_zero;
  logic [5:0] s1_a, s1_b, s1_sum;
  logic       s3_valid, s3_ready, s3_carry, s3_sub, s3_rvalid, s3_rready, s3_co, s3_ovf, s3_zero;
  logic [5:0] s3_a, s3_b, s3_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(op_valid), .ready_o(op_ready),
    .data0_i(op_a), .data1_i(op_b), .carry_i(op_carry), .sub_i(op_sub),
    .valid_o(res_valid), .ready_i(res_ready), .sum_o(res_sum), .carry_o(res_carry),
    .overflow_o(res_ovf), .zero_o(res_zero)
  );

  adder_pipe #(.WIDTH(6), .CHUNK(6)) dut_s1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(s1_valid), .ready_o(s1_ready),
    .data0_i(s1_a), .data1_i(s1_b), .carry_i(s1_carry), .sub_i(s1_sub),
    .valid_o(s1_rvalid), .ready_i(s1_rready), .sum_o(s1_sum), .carry_o(s1_co),
    .overflow_o(s1_ovf), .zero_o(s1_zero)
  );

  adder_pipe #(.WIDTH(6), .CHUNK(2)) dut_s3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(s3_valid), .ready_o(s3_ready),
    .data0_i(s3_a), .data1_i(s3_b), .carry_i(s3_carry), .sub_i(s3_sub),
    .valid_o(s3_rvalid), .ready_i(s3_rready), .sum_o(s3_sum), .carry_o(s3_co),
    .overflow_o(s3_ovf), .zero_o(s3_zero)
  );

  // Reference: {overflow, carry, sum} from plain integer arithmetic on the operand values.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    logic [32:0] wide;
    logic [31:0] s;
    logic        c, v;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s = wide[31:0];
      c = wide[32];
      v = (a[31] == b[31]) && (s[31] != a[31]);
    end else begin
      wide = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      s = wide[31:0];
      c = ({1'b0, a} >= ({1'b0, b} + {32'd0, cin}));
      v = (a[31] != b[31]) && (s[31] != a[31]);
    end
    return {v, c, s};
  endfunction

  // Drives one op on the main DUT and waits (bounded) for its result; no checking here.
  task automatic issue_one(input logic [31:0] a, input logic [31:0] b, input logic c,
                           input logic s, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; op_carry = c; op_sub = s; op_valid = 1'b1; res_ready = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      op_valid = 1'b0;
      if (res_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b1; op_a = $urandom; op_b = $urandom;
    op_carry = 1'b1; op_sub = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", res_valid); end
    if (res_sum !== 32'd0) begin bad++; $display("FAIL reset sum: got %h want 0", res_sum); end
    if (res_carry !== 1'b0) begin bad++; $display("FAIL reset carry: got %b want 0", res_carry); end
    if (res_ovf !== 1'b0) begin bad++; $display("FAIL reset ovf: got %b want 0", res_ovf); end
    if (res_zero !== 1'b1) begin bad++; $display("FAIL reset zero: got %b want 1", res_zero); end
    if (op_ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", op_ready); end
    rst_n = 1'b1; op_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin
        bad++; $display("FAIL reset ghost: got valid %b want 0 (cycle %0d)", res_valid, i);
      end
    end
  endtask

  task automatic test_add_wrap;
    logic [31:0] ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] ts [2] = '{32'h0000_0000, 32'h8000_0000};
    logic        tc [2] = '{1'b1, 1'b0};
    logic        tv [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      issue_one(ta[i], 32'd1, 1'b0, 1'b0, lat);
      total += 5;
      if (lat !== 4) begin bad++; $display("FAIL add latency %0d: got %0d want 4", i, lat); end
      if (res_sum !== ts[i]) begin bad++; $display("FAIL add sum %0d: got %h want %h", i, res_sum, ts[i]); end
      if (res_carry !== tc[i]) begin bad++; $display("FAIL add carry %0d: got %b want %b", i, res_carry, tc[i]); end
      if (res_ovf !== tv[i]) begin bad++; $display("FAIL add ovf %0d: got %b want %b", i, res_ovf, tv[i]); end
      if (res_zero !== (ts[i] == 0)) begin bad++; $display("FAIL add zero %0d: got %b", i, res_zero); end
    end
  endtask

  task automatic test_subtract;
    logic [31:0] ta [3] = '{32'd5, 32'h8000_0000, 32'd10};
    logic [31:0] tb [3] = '{32'd7, 32'd1, 32'd3};
    logic        tb_in [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ts [3] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd6};
    logic        tc [3] = '{1'b0, 1'b1, 1'b1};
    logic        tv [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue_one(ta[i], tb[i], tb_in[i], 1'b1, lat);
      total += 4;
      if (lat !== 4) begin bad++; $display("FAIL sub latency %0d: got %0d want 4", i, lat); end
      if (res_sum !== ts[i]) begin bad++; $display("FAIL sub sum %0d: got %h want %h", i, res_sum, ts[i]); end
      if (res_carry !== tc[i]) begin bad++; $display("FAIL sub carry %0d: got %b want %b", i, res_carry, tc[i]); end
      if (res_ovf !== tv[i]) begin bad++; $display("FAIL sub ovf %0d: got %b want %b", i, res_ovf, tv[i]); end
    end
  endtask

  // 16 random ops; with_bp selects the 1-0-0-1-1-0 ready pattern, otherwise ready is held high.
  task automatic test_stream(input bit with_bp);
    int pat [6] = '{1, 0, 0, 1, 1, 0};
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [31:0] a, b, p_sum;
    logic c, s, p_stall, p_c, p_v;
    int issued = 0, got = 0, cyc = 0;
    a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
    p_stall = 1'b0; p_sum = '0; p_c = 1'b0; p_v = 1'b0;
    while ((issued < 16 || got < 16) && cyc < 400) begin
      @(negedge clk);
      res_ready = with_bp ? (pat[cyc % 6] != 0) : 1'b1;
      op_valid = (issued < 16);
      op_a = a; op_b = b; op_carry = c; op_sub = s;
      #1;
      total++;
      if (op_ready !== !(res_valid && !res_ready)) begin
        bad++; $display("FAIL stream ready: got %b valid %b ready_in %b", op_ready, res_valid, res_ready);
      end
      if (p_stall) begin
        total++;
        if ({res_valid, res_sum, res_carry, res_ovf} !== {1'b1, p_sum, p_c, p_v}) begin
          bad++; $display("FAIL stall hold: got %h/%b/%b want %h/%b/%b", res_sum, res_carry,
                          res_ovf, p_sum, p_c, p_v);
        end
      end
      if (res_valid === 1'b1 && res_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream extra: got %h want nothing", res_sum);
        end else begin
          e = exp_q.pop_front();
          if ({res_ovf, res_carry, res_sum} !== e || res_zero !== (e[31:0] == 32'd0)) begin
            bad++; $display("FAIL stream result %0d: got %b/%b/%h/%b want %b/%b/%h", got,
                            res_ovf, res_carry, res_sum, res_zero, e[33], e[32], e[31:0]);
          end
        end
        got++;
      end
      p_stall = res_valid && !res_ready;
      p_sum = res_sum; p_c = res_carry; p_v = res_ovf;
      if (op_valid && op_ready) begin
        exp_q.push_back(ref_op(a, b, c, s));
        issued++;
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    op_valid = 1'b0;
    total++;
    if (got != 16 || issued != 16 || exp_q.size() != 0) begin
      bad++; $display("FAIL stream count: got %0d results of %0d issued, want 16", got, issued);
    end
    if (!with_bp) begin
      total++;
      if (cyc != 20) begin bad++; $display("FAIL back_to_back cycles: got %0d want 20", cyc); end
    end
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL stream duplicate: got valid %b want 0", res_valid); end
    end
  endtask

  task automatic test_reset_midstream;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op_a = $urandom; op_b = $urandom; op_carry = 1'b0; op_sub = 1'b0;
    end
    @(negedge clk);
    #1;
    total += 2;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL midreset stalled: got valid %b want 1", res_valid); end
    if (op_ready !== 1'b0) begin bad++; $display("FAIL midreset ready: got %b want 0", op_ready); end
    rst_n = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; op_valid = 1'b0;
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL midreset valid: got %b want 0", res_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL midreset ghost: got valid %b want 0", res_valid); end
    end
  endtask

  task automatic test_degenerate;
    int lat;
    @(negedge clk);
    s1_a = 6'd63; s1_b = 6'd1; s1_carry = 1'b0; s1_sub = 1'b0; s1_valid = 1'b1; s1_rready = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); lat++; @(negedge clk); s1_valid = 1'b0;
      if (s1_rvalid === 1'b1) break;
    end
    total += 4;
    if (lat !== 1) begin bad++; $display("FAIL w6c6 latency: got %0d want 1", lat); end
    if (s1_sum !== 6'd0) begin bad++; $display("FAIL w6c6 sum: got %h want 00", s1_sum); end
    if (s1_co !== 1'b1) begin bad++; $display("FAIL w6c6 carry: got %b want 1", s1_co); end
    if (s1_zero !== 1'b1) begin bad++; $display("FAIL w6c6 zero: got %b want 1", s1_zero); end

    s3_a = 6'b011111; s3_b = 6'b000001; s3_carry = 1'b0; s3_sub = 1'b0;
    s3_valid = 1'b1; s3_rready = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); lat++; @(negedge clk); s3_valid = 1'b0;
      if (s3_rvalid === 1'b1) break;
    end
    total += 4;
    if (lat !== 3) begin bad++; $display("FAIL w6c2 latency: got %0d want 3", lat); end
    if (s3_sum !== 6'b100000) begin bad++; $display("FAIL w6c2 sum: got %b want 100000", s3_sum); end
    if (s3_ovf !== 1'b1) begin bad++; $display("FAIL w6c2 ovf: got %b want 1", s3_ovf); end
    if (s3_co !== 1'b0) begin bad++; $display("FAIL w6c2 carry: got %b want 0", s3_co); end
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_carry = 1'b0; op_sub = 1'b0;
    res_ready = 1'b1;
    s1_valid = 1'b0; s1_a = '0; s1_b = '0; s1_carry = 1'b0; s1_sub = 1'b0; s1_rready = 1'b1;
    s3_valid = 1'b0; s3_a = '0; s3_b = '0; s3_carry = 1'b0; s3_sub = 1'b0; s3_rready = 1'b1;
    test_reset();
    test_add_wrap();
    test_subtract();
    test_stream(1'b0);
    test_stream(1'b1);
    test_reset_midstream();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
